// File: rtl/sv32_ptw.sv
// rtl/sv32_ptw.sv - Sv32 page-table walker that fills the translation tag RAM on a miss.
module sv32_ptw #(
    parameter int TAG_RAM_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH          = 20,
    parameter int PAYLOAD_WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid_i,
    input  logic [19:0]                   req_vpn_i,
    input  logic [21:0]                   satp_ppn_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          fault_o,
    output logic                          mem_valid_o,
    output logic [33:0]                   mem_addr_o,
    input  logic                          mem_ready_i,
    input  logic [31:0]                   mem_rdata_i,
    output logic [TAG_RAM_ADDR_WIDTH-1:0] tag_idx_o,
    output logic [TAG_WIDTH-1:0]          tag_o,
    output logic [PAYLOAD_WIDTH-1:0]      tag_payload_o,
    output logic                          tag_we_o,
    output logic                          tag_valid_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        L1    = 3'd1,
        L0    = 3'd2,
        FILL  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic        mem_valid_q;
    logic [33:0] mem_addr_q;
    logic [19:0] vpn_q;
    logic [31:0] payload_q;
    logic        tag_we_q;

    logic        pte_v;
    logic        pte_r;
    logic        pte_w;
    logic        pte_x;
    logic        pte_invalid;
    logic        pte_leaf;
    logic        pte_misaligned;
    logic        pte_fault;

    // Only structural validity is judged here; permissions travel in the payload.
    assign pte_v          = mem_rdata_i[0];
    assign pte_r          = mem_rdata_i[1];
    assign pte_w          = mem_rdata_i[2];
    assign pte_x          = mem_rdata_i[3];
    assign pte_invalid    = !pte_v || (!pte_r && pte_w);
    assign pte_leaf       = pte_r || pte_x;
    assign pte_misaligned = |mem_rdata_i[19:10];
    assign pte_fault      = pte_invalid
                         || (pte_leaf && (state_q == L1) && pte_misaligned)
                         || (!pte_leaf && (state_q == L0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            vpn_q       <= '0;
            payload_q   <= '0;
            tag_we_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            tag_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q     <= L1;
                        busy_q      <= 1'b1;
                        vpn_q       <= req_vpn_i;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= {satp_ppn_i, req_vpn_i[19:10], 2'b00};
                    end
                end
                L1, L0: begin
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        if (pte_fault) begin
                            state_q <= FAULT;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (pte_leaf) begin
                            state_q  <= FILL;
                            done_q   <= 1'b1;
                            tag_we_q <= 1'b1;
                            // Superpage leaves splice VPN0 into the PPN0 field.
                            payload_q <= (state_q == L1)
                                ? {mem_rdata_i[31:20], vpn_q[9:0], mem_rdata_i[9:0]}
                                : mem_rdata_i;
                        end else begin
                            state_q     <= L0;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {mem_rdata_i[31:10], vpn_q[9:0], 2'b00};
                        end
                    end
                end
                FILL, FAULT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fault_o       = fault_q;
    assign mem_valid_o   = mem_valid_q;
    assign mem_addr_o    = mem_addr_q;
    assign tag_idx_o     = vpn_q[TAG_RAM_ADDR_WIDTH-1:0];
    assign tag_o         = TAG_WIDTH'(vpn_q);
    assign tag_payload_o = PAYLOAD_WIDTH'(payload_q);
    assign tag_we_o      = tag_we_q;
    assign tag_valid_o   = tag_we_q;

endmodule
